territory_cursor_ctrl: RTL

Turns the raw 4-keycode USB HID word into territory-cursor navigation for the map.
- Detects newly pressed keys against its own previous-keycode register.
- Steps and wraps the highlighted territory index, with hold-to-auto-repeat.
- Hands an Enter selection to the game FSM through a valid/ready handshake.
- Sits between the keyboard keycode register and the turn/game FSM. Its cursor outputs also drive map highlight redraw.

---
 rtl/territory_cursor_ctrl_if.sv | 25 ++
 rtl/territory_cursor_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/territory_cursor_ctrl_if.sv
// Keyboard/game-FSM side signals of the territory cursor controller.
// The slave modport is the controller; the master modport is whoever drives keys and accepts selections.
interface territory_cursor_ctrl_if #(
  parameter int unsigned IDX_W = 6
) ();
  logic             enable;
  logic [31:0]      keycode;
  logic             sel_ready;
  logic [IDX_W-1:0] cursor_idx;
  logic [IDX_W-1:0] prev_cursor_idx;
  logic             cursor_moved;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             cancel;

  modport master (
    output enable, keycode, sel_ready,
    input  cursor_idx, prev_cursor_idx, cursor_moved, sel_valid, sel_idx, cancel
  );

  modport slave (
    input  enable, keycode, sel_ready,
    output cursor_idx, prev_cursor_idx, cursor_moved, sel_valid, sel_idx, cancel
  );
endinterface

// File: rtl/territory_cursor_ctrl.sv
// Converts HID keycodes into territory cursor steps with hold-to-repeat, plus an Enter
// selection handed to the game FSM over valid/ready and an Escape cancel pulse.
module territory_cursor_ctrl #(
  parameter int unsigned NUM_TERR      = 42,
  parameter int unsigned IDX_W         = $clog2(NUM_TERR),
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input logic                    clk,
  input logic                    reset_n,
  territory_cursor_ctrl_if.slave bus
);

  localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_TERR - 1);

  typedef enum logic [1:0] {StIdle, StReady, StHold, StSelect} state_e;

  state_e           r_state_q, r_state_d;
  logic [31:0]      r_prev_key_q;
  logic [IDX_W-1:0] r_cursor_q, r_cursor_d;
  logic [IDX_W-1:0] r_prev_cursor_q, r_prev_cursor_d;
  logic [IDX_W-1:0] r_sel_idx_q, r_sel_idx_d;
  logic             r_sel_valid_q, r_sel_valid_d;
  logic             r_moved_q, r_moved_d;
  logic             r_cancel_q, r_cancel_d;
  logic [CntW-1:0]  r_cnt_q, r_cnt_d;

  logic w_held_next, w_held_prev, w_held_enter, w_held_esc;
  logic w_was_next, w_was_prev, w_was_enter, w_was_esc;
  logic w_new_next, w_new_prev, w_new_enter, w_new_esc;
  logic w_step, w_step_fwd;

  // Byte position within the HID report carries no meaning; any slot may hold a key.
  function automatic logic any_byte(input logic [31:0] kc, input logic [7:0] a,
                                    input logic [7:0] b, input logic [7:0] c);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (kc[8*i +: 8] == a || kc[8*i +: 8] == b || kc[8*i +: 8] == c) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    w_held_next  = any_byte(bus.keycode, 8'h4F, 8'h51, 8'h07);
    w_held_prev  = any_byte(bus.keycode, 8'h50, 8'h52, 8'h04);
    w_held_enter = any_byte(bus.keycode, 8'h28, 8'h28, 8'h28);
    w_held_esc   = any_byte(bus.keycode, 8'h29, 8'h29, 8'h29);
    w_was_next   = any_byte(r_prev_key_q, 8'h4F, 8'h51, 8'h07);
    w_was_prev   = any_byte(r_prev_key_q, 8'h50, 8'h52, 8'h04);
    w_was_enter  = any_byte(r_prev_key_q, 8'h28, 8'h28, 8'h28);
    w_was_esc    = any_byte(r_prev_key_q, 8'h29, 8'h29, 8'h29);
    w_new_next   = w_held_next  & ~w_was_next;
    w_new_prev   = w_held_prev  & ~w_was_prev;
    w_new_enter  = w_held_enter & ~w_was_enter;
    w_new_esc    = w_held_esc   & ~w_was_esc;
  end

  always_comb begin
    r_state_d       = r_state_q;
    r_cursor_d      = r_cursor_q;
    r_prev_cursor_d = r_prev_cursor_q;
    r_sel_idx_d     = r_sel_idx_q;
    r_sel_valid_d   = r_sel_valid_q;
    r_moved_d       = 1'b0;
    r_cancel_d      = 1'b0;
    r_cnt_d         = r_cnt_q;
    w_step          = 1'b0;
    w_step_fwd      = 1'b0;

    unique case (r_state_q)
      StIdle: begin
        if (bus.enable) r_state_d = StReady;
      end
      StSelect: begin
        if (bus.sel_ready) begin
          r_sel_valid_d = 1'b0;
          r_state_d     = bus.enable ? StReady : StIdle;
        end
      end
      StReady, StHold: begin
        if (!bus.enable) begin
          r_state_d = StIdle;
          r_cnt_d   = '0;
        end else if (w_new_enter) begin
          r_sel_idx_d   = r_cursor_q;
          r_sel_valid_d = 1'b1;
          r_cnt_d       = '0;
          r_state_d     = StSelect;
        end else if (w_new_esc) begin
          r_cancel_d = 1'b1;
        end else if (r_state_q == StReady) begin
          // Opposite directions pressed together cancel out.
          if (w_new_next ^ w_new_prev) begin
            w_step     = 1'b1;
            w_step_fwd = w_new_next;
            r_cnt_d    = CntW'(REPEAT_DELAY);
            r_state_d  = StHold;
          end
        end else if (w_held_next ^ w_held_prev) begin
          if (r_cnt_q == CntW'(1)) begin
            w_step     = 1'b1;
            w_step_fwd = w_held_next;
            r_cnt_d    = CntW'(REPEAT_PERIOD);
          end else begin
            r_cnt_d = r_cnt_q - CntW'(1);
          end
        end else begin
          r_cnt_d   = '0;
          r_state_d = StReady;
        end
      end
      default: r_state_d = StIdle;
    endcase

    if (w_step) begin
      r_prev_cursor_d = r_cursor_q;
      r_moved_d       = 1'b1;
      if (w_step_fwd) r_cursor_d = (r_cursor_q == LastIdx) ? '0 : r_cursor_q + IDX_W'(1);
      else            r_cursor_d = (r_cursor_q == '0) ? LastIdx : r_cursor_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q       <= StIdle;
      r_prev_key_q    <= '0;
      r_cursor_q      <= '0;
      r_prev_cursor_q <= '0;
      r_sel_idx_q     <= '0;
      r_sel_valid_q   <= 1'b0;
      r_moved_q       <= 1'b0;
      r_cancel_q      <= 1'b0;
      r_cnt_q         <= '0;
    end else begin
      r_state_q       <= r_state_d;
      r_prev_key_q    <= bus.keycode;
      r_cursor_q      <= r_cursor_d;
      r_prev_cursor_q <= r_prev_cursor_d;
      r_sel_idx_q     <= r_sel_idx_d;
      r_sel_valid_q   <= r_sel_valid_d;
      r_moved_q       <= r_moved_d;
      r_cancel_q      <= r_cancel_d;
      r_cnt_q         <= r_cnt_d;
    end
  end

  assign bus.cursor_idx      = r_cursor_q;
  assign bus.prev_cursor_idx = r_prev_cursor_q;
  assign bus.cursor_moved    = r_moved_q;
  assign bus.sel_valid       = r_sel_valid_q;
  assign bus.sel_idx         = r_sel_idx_q;
  assign bus.cancel          = r_cancel_q;

endmodule
